// File: rtl/ir_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ir_tx_pkg
// Brief    : Shared types and constants for the IR packet transmitter.
// Revision : 1.0 - initial release
// ============================================================================
package ir_tx_pkg;

  // Packet sequencer states; GAP is shared between all bursts
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    GAP    = 3'd2,
    CARSEL = 3'd3,
    RIGHT  = 3'd4,
    LEFT   = 3'd5,
    BACK   = 3'd6,
    FWD    = 3'd7
  } state_t;

  // Bit positions inside COMMAND
  localparam int CMD_RIGHT = 3;
  localparam int CMD_LEFT  = 2;
  localparam int CMD_BACK  = 1;
  localparam int CMD_FWD   = 0;

  // Larger of two integers, used to size the pulse counter
  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Burst that follows the gap after burst s; FWD is the last one
  function automatic state_t next_burst(input state_t s);
    state_t n;
    n = IDLE;
    case (s)
      START:   n = CARSEL;
      CARSEL:  n = RIGHT;
      RIGHT:   n = LEFT;
      LEFT:    n = BACK;
      BACK:    n = FWD;
      default: n = IDLE;
    endcase
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ir_carrier_gen.sv
`default_nettype none
// ============================================================================
// Module   : ir_carrier_gen
// Brief    : Carrier period counter for the IR transmitter. Provides the
//            carrier level for the coming cycle and a period-wrap pulse.
// Revision : 1.0 - initial release
// ============================================================================
module ir_carrier_gen #(
  parameter int CARRIER_HALF = 1389
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic carrier,
  output logic period_wrap
);

  localparam int              c_CW   = $clog2(CARRIER_HALF) + 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(2 * CARRIER_HALF - 1);
  localparam logic [c_CW-1:0] c_HALF = c_CW'(CARRIER_HALF);

  logic [c_CW-1:0] r_count;
  logic [c_CW-1:0] w_count_next;

  // Last count of the current carrier period
  assign period_wrap = (r_count == c_LAST);

  // Next count: restart and period end both return to zero
  always_comb begin
    w_count_next = r_count + c_CW'(1);
    if (restart || period_wrap) begin
      w_count_next = '0;
    end
  end

  // Level the carrier will have after the next edge (high in first half)
  assign carrier = (w_count_next < c_HALF);

  // Period counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ir_packet_tx.sv
`default_nettype none
// ============================================================================
// Module   : ir_packet_tx
// Brief    : Sends one IR remote-control packet per SEND_PACKET strobe:
//            START, CARSEL, RIGHT, LEFT, BACKWARD, FORWARD bursts, each
//            followed by a silent gap. Burst lengths of the command bits
//            depend on the command latched at acceptance.
// Options  : IR_TX_QUEUE_EN - one-deep request queue; a strobe while busy
//            starts another packet straight after the current one.
// Revision : 1.0 - initial release
// ============================================================================
module ir_packet_tx #(
  parameter int CARRIER_HALF    = 1389,
  parameter int START_PULSES    = 191,
  parameter int CARSEL_PULSES   = 47,
  parameter int GAP_PULSES      = 25,
  parameter int ASSERT_PULSES   = 47,
  parameter int DEASSERT_PULSES = 22
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       send_packet,
  input  logic [3:0] command,
  output logic       ir_led,
  output logic       busy
);

  import ir_tx_pkg::*;

  localparam int c_MAX_PULSES = max_of(max_of(max_of(START_PULSES, CARSEL_PULSES),
                                              max_of(GAP_PULSES, ASSERT_PULSES)),
                                       DEASSERT_PULSES);
  localparam int c_PW = $clog2(c_MAX_PULSES) + 1;

  localparam logic [c_PW-1:0] c_START_LAST    = c_PW'(START_PULSES - 1);
  localparam logic [c_PW-1:0] c_CARSEL_LAST   = c_PW'(CARSEL_PULSES - 1);
  localparam logic [c_PW-1:0] c_GAP_LAST      = c_PW'(GAP_PULSES - 1);
  localparam logic [c_PW-1:0] c_ASSERT_LAST   = c_PW'(ASSERT_PULSES - 1);
  localparam logic [c_PW-1:0] c_DEASSERT_LAST = c_PW'(DEASSERT_PULSES - 1);

  state_t          r_state;
  state_t          r_gap_ret;
  logic [3:0]      r_cmd;
  logic [c_PW-1:0] r_pulse;
  logic            r_ir_led;
  logic            r_busy;

  logic [c_PW-1:0] w_last;
  logic            w_wrap;
  logic            w_carrier;
  logic            w_accept;
  logic            w_advance;
  logic            w_restart;
  logic            w_requeue;

  assign ir_led = r_ir_led;
  assign busy   = r_busy;

  ir_carrier_gen #(
    .CARRIER_HALF (CARRIER_HALF)
  ) u_carrier (
    .clk         (clk),
    .reset       (reset),
    .restart     (w_restart),
    .carrier     (w_carrier),
    .period_wrap (w_wrap)
  );

  // Final pulse index of the current state's burst or gap
  always_comb begin
    w_last = c_GAP_LAST;
    case (r_state)
      START:   w_last = c_START_LAST;
      CARSEL:  w_last = c_CARSEL_LAST;
      RIGHT:   w_last = r_cmd[CMD_RIGHT] ? c_ASSERT_LAST : c_DEASSERT_LAST;
      LEFT:    w_last = r_cmd[CMD_LEFT]  ? c_ASSERT_LAST : c_DEASSERT_LAST;
      BACK:    w_last = r_cmd[CMD_BACK]  ? c_ASSERT_LAST : c_DEASSERT_LAST;
      FWD:     w_last = r_cmd[CMD_FWD]   ? c_ASSERT_LAST : c_DEASSERT_LAST;
      default: w_last = c_GAP_LAST;
    endcase
  end

  assign w_accept  = (r_state == IDLE) && send_packet;
  assign w_advance = (r_state != IDLE) && w_wrap && (r_pulse == w_last);
  // Every state change restarts the carrier from count 0
  assign w_restart = w_accept || w_advance;

`ifdef IR_TX_QUEUE_EN
  logic r_pending;

  // A pending request, or one arriving on the final wrap, chains a new packet
  assign w_requeue = r_pending || send_packet;

  // One-deep request flag: set by strobes while busy, cleared on hand-over
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending <= 1'b0;
    end else if ((r_state == GAP) && w_advance && (r_gap_ret == IDLE)) begin
      r_pending <= 1'b0;
    end else if ((r_state != IDLE) && send_packet) begin
      r_pending <= 1'b1;
    end
  end
`else
  // Strobes during a packet are simply dropped
  assign w_requeue = 1'b0;
`endif

  // Carrier periods completed in the current state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pulse <= '0;
    end else if (w_restart) begin
      r_pulse <= '0;
    end else if (w_wrap && (r_state != IDLE)) begin
      r_pulse <= r_pulse + c_PW'(1);
    end
  end

  // Packet sequencer with registered LED and busy outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_gap_ret <= IDLE;
      r_cmd     <= 4'b0000;
      r_ir_led  <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (send_packet) begin
            r_state  <= START;
            r_cmd    <= command;
            r_ir_led <= 1'b1;
            r_busy   <= 1'b1;
          end else begin
            r_ir_led <= 1'b0;
            r_busy   <= 1'b0;
          end
        end
        GAP: begin
          if (w_advance) begin
            if (r_gap_ret != IDLE) begin
              r_state  <= r_gap_ret;
              r_ir_led <= 1'b1;
            end else if (w_requeue) begin
              r_state  <= START;
              r_cmd    <= command;
              r_ir_led <= 1'b1;
              r_busy   <= 1'b1;
            end else begin
              r_state  <= IDLE;
              r_ir_led <= 1'b0;
              r_busy   <= 1'b0;
            end
          end else begin
            r_ir_led <= 1'b0;
          end
        end
        default: begin
          if (w_advance) begin
            r_state   <= GAP;
            r_gap_ret <= next_burst(r_state);
            r_ir_led  <= 1'b0;
          end else begin
            r_ir_led  <= w_carrier;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ir_packet_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ir_packet_tx
// Brief    : Self-checking bench for ir_packet_tx with small timing
//            parameters. Expected LED waveforms come from a burst-list model.
//            Expectations follow IR_TX_QUEUE_EN when it is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ir_packet_tx;

  localparam int H  = 2;
  localparam int NS = 4;
  localparam int NC = 2;
  localparam int NG = 1;
  localparam int NA = 3;
  localparam int ND = 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       send_packet;
  logic [3:0] command;
  logic       ir_led;
  logic       busy;

  int   n_checks = 0;
  int   n_errors = 0;
  logic obs_q[$];
  logic exp_q[$];

  ir_packet_tx #(
    .CARRIER_HALF    (H),
    .START_PULSES    (NS),
    .CARSEL_PULSES   (NC),
    .GAP_PULSES      (NG),
    .ASSERT_PULSES   (NA),
    .DEASSERT_PULSES (ND)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .send_packet (send_packet),
    .command     (command),
    .ir_led      (ir_led),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Model: a burst is N carrier periods of H high then H low; a gap is silent
  function automatic void model_burst(input int periods, input bit lit);
    for (int p = 0; p < periods; p++)
      for (int c = 0; c < 2 * H; c++)
        exp_q.push_back(lit && (c < H));
  endfunction

  function automatic void model_packet(input logic [3:0] cmd);
    model_burst(NS, 1'b1); model_burst(NG, 1'b0);
    model_burst(NC, 1'b1); model_burst(NG, 1'b0);
    for (int b = 3; b >= 0; b--) begin
      model_burst(cmd[b] ? NA : ND, 1'b1);
      model_burst(NG, 1'b0);
    end
  endfunction

  // Index of first cycle where observed and modelled LED differ, -1 if none
  function automatic int first_diff();
    int n;
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      if (obs_q[i] !== exp_q[i]) return i;
    if (obs_q.size() != exp_q.size()) return n;
    return -1;
  endfunction

  // Strobe now, then record the LED for every busy cycle; optional poke at a cycle
  task automatic run_packet(input logic [3:0] cmd, input int poke_at,
                            input logic [3:0] poke_cmd, input bit poke_strobe,
                            output int busy_cycles, output bit timed_out);
    obs_q.delete();
    busy_cycles = 0;
    timed_out   = 1'b0;
    command     = cmd;
    send_packet = 1'b1;
    @(posedge clk); #1;
    send_packet = 1'b0;
    while (busy === 1'b1) begin
      obs_q.push_back(ir_led);
      busy_cycles++;
      if (busy_cycles == poke_at) begin
        command     = poke_cmd;
        send_packet = poke_strobe;
      end else begin
        send_packet = 1'b0;
      end
      if (busy_cycles > 400) begin
        timed_out = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    send_packet = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; send_packet = 1'b0; command = 4'hF;
    idle_cycles(3);
    n_checks++;
    if (ir_led !== 1'b0) begin n_errors++; $display("FAIL reset_ir_led: observed %b required 0", ir_led); end
    n_checks++;
    if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: observed %b required 0", busy); end
    send_packet = 1'b1;
    idle_cycles(1);
    send_packet = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_strobe_ignored: busy observed %b required 0", busy); end
    reset = 1'b0;
    idle_cycles(2);
    n_checks++;
    if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_release_idle: busy observed %b required 0", busy); end
  endtask

  task automatic test_fixed_patterns();
    logic [3:0] cmds  [3] = '{4'b0000, 4'b1111, 4'b1010};
    int         lens  [3] = '{64, 96, 80};
    int         pokes [3] = '{0, 0, 5};
    int cyc, d;
    bit to;
    for (int t = 0; t < 3; t++) begin
      exp_q.delete();
      model_packet(cmds[t]);
      run_packet(cmds[t], pokes[t], 4'b0101, 1'b0, cyc, to);
      n_checks++;
      if (to || cyc != lens[t]) begin
        n_errors++;
        $display("FAIL fixed_len cmd=%b: busy cycles observed %0d required %0d", cmds[t], cyc, lens[t]);
      end
      d = first_diff();
      n_checks++;
      if (d != -1) begin
        n_errors++;
        $display("FAIL fixed_wave cmd=%b: first differing cycle %0d (observed %0d cycles, required %0d)",
                 cmds[t], d + 1, obs_q.size(), exp_q.size());
      end
      idle_cycles(3);
    end
  endtask

  task automatic test_random();
    logic [3:0] cmd;
    int cyc, d, len;
    bit to;
    for (int t = 0; t < 6; t++) begin
      cmd = 4'($urandom);
      len = 2 * H * (NS + NC + 6 * NG);
      for (int b = 0; b < 4; b++) len += 2 * H * (cmd[b] ? NA : ND);
      exp_q.delete();
      model_packet(cmd);
      run_packet(cmd, $urandom_range(1, 60), 4'($urandom), 1'b0, cyc, to);
      n_checks++;
      if (to || cyc != len) begin
        n_errors++;
        $display("FAIL random_len cmd=%b: busy cycles observed %0d required %0d", cmd, cyc, len);
      end
      d = first_diff();
      n_checks++;
      if (d != -1) begin
        n_errors++;
        $display("FAIL random_wave cmd=%b: first differing cycle %0d", cmd, d + 1);
      end
      idle_cycles($urandom_range(1, 4));
    end
  endtask

  task automatic test_strobe_while_busy();
    int cyc, d;
    bit to;
    exp_q.delete();
    model_packet(4'b0000);
`ifdef IR_TX_QUEUE_EN
    model_packet(4'b1111);
`endif
    run_packet(4'b0000, 20, 4'b1111, 1'b1, cyc, to);
    n_checks++;
    if (to || cyc != exp_q.size()) begin
      n_errors++;
      $display("FAIL busy_strobe_len: busy cycles observed %0d required %0d", cyc, exp_q.size());
    end
    d = first_diff();
    n_checks++;
    if (d != -1) begin
      n_errors++;
      $display("FAIL busy_strobe_wave: first differing cycle %0d", d + 1);
    end
    idle_cycles(4);
    n_checks++;
    if (busy !== 1'b0) begin n_errors++; $display("FAIL busy_strobe_idle: busy observed %b required 0", busy); end
  endtask

  task automatic test_reset_mid_packet();
    int at [2] = '{21, 30};
    int cyc, d;
    bit to;
    for (int t = 0; t < 2; t++) begin
      command = 4'b1111; send_packet = 1'b1;
      idle_cycles(1);
      send_packet = 1'b0;
      for (int c = 1; c < at[t]; c++) begin
        send_packet = (c == 10);
        idle_cycles(1);
      end
      send_packet = 1'b0;
      reset = 1'b1;
      idle_cycles(1);
      n_checks++;
      if (ir_led !== 1'b0) begin n_errors++; $display("FAIL midreset_ir_led at %0d: observed %b required 0", at[t], ir_led); end
      n_checks++;
      if (busy !== 1'b0) begin n_errors++; $display("FAIL midreset_busy at %0d: observed %b required 0", at[t], busy); end
      reset = 1'b0;
      idle_cycles(3);
      n_checks++;
      if (busy !== 1'b0) begin n_errors++; $display("FAIL midreset_stays_idle at %0d: busy observed %b required 0", at[t], busy); end
      exp_q.delete();
      model_packet(4'b0000);
      run_packet(4'b0000, 0, 4'b0000, 1'b0, cyc, to);
      n_checks++;
      if (to || cyc != 64) begin n_errors++; $display("FAIL midreset_clean_len: busy cycles observed %0d required 64", cyc); end
      d = first_diff();
      n_checks++;
      if (d != -1) begin n_errors++; $display("FAIL midreset_clean_wave: first differing cycle %0d", d + 1); end
      idle_cycles(2);
    end
  endtask

  task automatic test_back_to_back();
    int cyc1, cyc2, d;
    bit to1, to2;
    run_packet(4'b0110, 0, 4'b0000, 1'b0, cyc1, to1);
    run_packet(4'b1001, 0, 4'b0000, 1'b0, cyc2, to2);
    n_checks++;
    if (to1 || cyc1 != 80) begin n_errors++; $display("FAIL b2b_first_len: busy cycles observed %0d required 80", cyc1); end
    exp_q.delete();
    model_packet(4'b1001);
    n_checks++;
    if (to2 || cyc2 != 80) begin n_errors++; $display("FAIL b2b_second_len: busy cycles observed %0d required 80", cyc2); end
    n_checks++;
    if (obs_q.size() == 0 || obs_q[0] !== 1'b1) begin
      n_errors++;
      $display("FAIL b2b_first_led: observed %0d recorded cycles, required LED 1 in first cycle", obs_q.size());
    end
    d = first_diff();
    n_checks++;
    if (d != -1) begin n_errors++; $display("FAIL b2b_second_wave: first differing cycle %0d", d + 1); end
    idle_cycles(2);
  endtask

  initial begin
    reset = 1'b1; send_packet = 1'b0; command = 4'b0000;
    test_reset();
    test_fixed_patterns();
    test_random();
    test_strobe_while_busy();
    test_reset_mid_packet();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
